// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order word requests to
// instruction memory, buffers responses and drives the registered IF/ID boundary.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_1000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_d,
    output logic        valid_d,
    output logic [31:0] inst_d,
    output logic [31:0] pc_d,
    output logic        err_d,
    output logic        fetch_halt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]   pc_f_q, pc_f_d;
    logic [31:0]   tag_mem_q [DEPTH];
    logic [31:0]   tag_mem_d [DEPTH];
    logic [AW-1:0] tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [31:0]   ib_pc_q [DEPTH];
    logic [31:0]   ib_pc_d [DEPTH];
    logic [31:0]   ib_inst_q [DEPTH];
    logic [31:0]   ib_inst_d [DEPTH];
    logic          ib_err_q [DEPTH];
    logic          ib_err_d [DEPTH];
    logic [AW-1:0] ib_wp_q, ib_wp_d, ib_rp_q, ib_rp_d;
    logic [CW-1:0] ib_cnt_q, ib_cnt_d;

    logic          id_valid_q, id_valid_d;
    logic [31:0]   id_inst_q, id_inst_d;
    logic [31:0]   id_pc_q, id_pc_d;
    logic          id_err_q, id_err_d;
    logic          halt_q, halt_d;

    logic [CW:0]   occupancy_s;
    logic          accept_s, live_s, resp_err_s;
    logic [31:0]   resp_pc_s;
    logic          load_s, push_s, pop_s;

    // Request gating from registered occupancy; also decodes the current response.
    always_comb begin
        occupancy_s = {1'b0, outstanding_q} + {1'b0, ib_cnt_q};
        imem_req    = rst && !halt_q && !redirect_valid && (occupancy_s < DEPTH_C);
        imem_addr   = {pc_f_q[31:2], 2'b00};
        accept_s    = imem_req && imem_gnt;
        resp_pc_s   = tag_mem_q[tag_rp_q];
        live_s      = imem_rvalid && (drop_q == {CW{1'b0}});
        resp_err_s  = imem_err || (resp_pc_s[1:0] != 2'b00);
    end

    // Next state for PC, tag/instruction FIFOs, drop counter, IF/ID and halt.
    always_comb begin
        pc_f_d        = pc_f_q;
        tag_mem_d     = tag_mem_q;
        tag_wp_d      = tag_wp_q;
        tag_rp_d      = tag_rp_q;
        outstanding_d = outstanding_q + CW'(accept_s) - CW'(imem_rvalid);
        drop_d        = drop_q;
        ib_pc_d       = ib_pc_q;
        ib_inst_d     = ib_inst_q;
        ib_err_d      = ib_err_q;
        ib_wp_d       = ib_wp_q;
        ib_rp_d       = ib_rp_q;
        ib_cnt_d      = ib_cnt_q;
        id_valid_d    = id_valid_q;
        id_inst_d     = id_inst_q;
        id_pc_d       = id_pc_q;
        id_err_d      = id_err_q;
        halt_d        = halt_q;
        load_s        = 1'b0;
        push_s        = 1'b0;
        pop_s         = 1'b0;

        if (accept_s) begin
            tag_mem_d[tag_wp_q] = pc_f_q;
            tag_wp_d            = tag_wp_q + AW'(1'b1);
        end else begin
            tag_wp_d = tag_wp_q;
        end

        if (imem_rvalid) begin
            tag_rp_d = tag_rp_q + AW'(1'b1);
            drop_d   = live_s ? drop_q : (drop_q - CW'(1'b1));
        end else begin
            tag_rp_d = tag_rp_q;
        end

        if (redirect_valid) begin
            // Every request still outstanding after this edge belongs to the old path.
            pc_f_d     = redirect_pc;
            id_valid_d = 1'b0;
            ib_wp_d    = {AW{1'b0}};
            ib_rp_d    = {AW{1'b0}};
            ib_cnt_d   = {CW{1'b0}};
            drop_d     = outstanding_d;
        end else begin
            pc_f_d = accept_s ? (pc_f_q + 32'd4) : pc_f_q;
            if (!stall_d || !id_valid_q) begin
                if (ib_cnt_q != {CW{1'b0}}) begin
                    id_pc_d   = ib_pc_q[ib_rp_q];
                    id_inst_d = ib_inst_q[ib_rp_q];
                    id_err_d  = ib_err_q[ib_rp_q];
                    load_s    = 1'b1;
                    pop_s     = 1'b1;
                    push_s    = live_s;
                end else if (live_s) begin
                    id_pc_d   = resp_pc_s;
                    id_inst_d = imem_rdata;
                    id_err_d  = resp_err_s;
                    load_s    = 1'b1;
                end else begin
                    id_valid_d = 1'b0;
                end
            end else begin
                push_s = live_s;
            end

            if (load_s) begin
                id_valid_d = 1'b1;
                halt_d     = halt_q || id_err_d;
            end else begin
                halt_d = halt_q;
            end

            if (push_s) begin
                ib_pc_d[ib_wp_q]   = resp_pc_s;
                ib_inst_d[ib_wp_q] = imem_rdata;
                ib_err_d[ib_wp_q]  = resp_err_s;
                ib_wp_d            = ib_wp_q + AW'(1'b1);
            end else begin
                ib_wp_d = ib_wp_q;
            end
            ib_rp_d  = pop_s ? (ib_rp_q + AW'(1'b1)) : ib_rp_q;
            ib_cnt_d = ib_cnt_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_f_q        <= RESET_PC;
            tag_mem_q     <= '{default: 32'h0000_0000};
            tag_wp_q      <= {AW{1'b0}};
            tag_rp_q      <= {AW{1'b0}};
            outstanding_q <= {CW{1'b0}};
            drop_q        <= {CW{1'b0}};
            ib_pc_q       <= '{default: 32'h0000_0000};
            ib_inst_q     <= '{default: 32'h0000_0000};
            ib_err_q      <= '{default: 1'b0};
            ib_wp_q       <= {AW{1'b0}};
            ib_rp_q       <= {AW{1'b0}};
            ib_cnt_q      <= {CW{1'b0}};
            id_valid_q    <= 1'b0;
            id_inst_q     <= 32'h0000_0000;
            id_pc_q       <= 32'h0000_0000;
            id_err_q      <= 1'b0;
            halt_q        <= 1'b0;
        end else begin
            pc_f_q        <= pc_f_d;
            tag_mem_q     <= tag_mem_d;
            tag_wp_q      <= tag_wp_d;
            tag_rp_q      <= tag_rp_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            ib_pc_q       <= ib_pc_d;
            ib_inst_q     <= ib_inst_d;
            ib_err_q      <= ib_err_d;
            ib_wp_q       <= ib_wp_d;
            ib_rp_q       <= ib_rp_d;
            ib_cnt_q      <= ib_cnt_d;
            id_valid_q    <= id_valid_d;
            id_inst_q     <= id_inst_d;
            id_pc_q       <= id_pc_d;
            id_err_q      <= id_err_d;
            halt_q        <= halt_d;
        end
    end

    assign valid_d    = id_valid_q;
    assign inst_d     = id_inst_q;
    assign pc_d       = id_pc_q;
    assign err_d      = id_err_q;
    assign fetch_halt = halt_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage MIPS32 pipeline: owns the fetch PC, issues word requests to instruction memory over a request/grant/response handshake, and buffers in-flight responses. It presents one instruction per cycle to decode through a registered IF/ID boundary. It honours decode stalls and branch/jump redirects, discarding wrong-path responses, and stops fetching after a faulting fetch reaches decode.

## Interface
- `RESET_PC`, 32'h1000, PC loaded on reset
- `DEPTH`, 2, max outstanding requests plus buffered entries (power of two, ≥2)
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  word-aligned fetch address, `{pc_f[31:2],2'b00}`
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response valid; responses return in request order, ≥1 cycle after grant
- `imem_rdata`  in  32  fetched instruction
- `imem_err`  in  1  access fault for this response
- `redirect_valid`  in  1  branch/jump taken; flush and refetch
- `redirect_pc`  in  32  new fetch PC
- `stall_d`  in  1  decode holds IF/ID register
- `valid_d`  out  1  IF/ID holds a live instruction
- `inst_d`  out  32  IF/ID instruction
- `pc_d`  out  32  IF/ID PC
- `err_d`  out  1  IF/ID instruction faulted (imem_err or misaligned PC)
- `fetch_halt`  out  1  sticky: faulting instruction delivered

## Operation
- State: `pc_f`; tag FIFO (DEPTH) of outstanding PCs; instruction FIFO (DEPTH) of {pc, inst, err}; `outstanding` and `drop_cnt` counters (log2(DEPTH)+1 bits); IF/ID register; `fetch_halt`.
- Issue: `imem_req = !fetch_halt && (outstanding + ififo_count < DEPTH)`, registered counts only. On `imem_req && imem_gnt`: push `pc_f` to tag FIFO, `pc_f <= pc_f + 4` (32-bit wrap, 32'hFFFFFFFC → 0).
- Response: on `imem_rvalid`, pop tag FIFO, `outstanding` decrements. If `drop_cnt != 0`, discard and decrement `drop_cnt`. Otherwise entry = {tag, imem_rdata, imem_err | tag[1:0]!=0}.
- Delivery: when `!stall_d || !valid_d`, IF/ID loads instruction-FIFO head; if FIFO empty, bypasses a live response directly; if neither, `valid_d <= 0`. Otherwise live response pushes to FIFO. IF/ID holds all fields while `stall_d && valid_d`.
- Redirect (priority over stall, issue, delivery): `pc_f <= redirect_pc`; `valid_d <= 0`; instruction FIFO cleared; `drop_cnt <= outstanding + (grant this cycle) - (response this cycle)`, plus existing `drop_cnt` accounting; no new request accepted in redirect cycle (`imem_req` masked).
- `fetch_halt` sets at the edge where IF/ID is loaded with `err=1` and not flushed; thereafter `imem_req=0`, buffered entries still drain. Cleared only by reset.
- Response with tag FIFO empty is a protocol violation; bench asserts it never occurs.

## Timing
- Reset values: `pc_f=RESET_PC`, counters 0, FIFOs empty, `valid_d=0`, `inst_d=0`, `pc_d=0`, `err_d=0`, `fetch_halt=0`, `imem_req=0` while rst low; `imem_req=1` in first cycle after release.
- Latency: grant in cycle N, response N+1 → `valid_d`/`inst_d` visible N+2 (bypass). Buffered path adds one cycle per queued entry.
- Throughput: 1 instruction/cycle with 1-cycle memory and no stall.
- Redirect in cycle R: first new-path request in R+1; earliest new-path `valid_d` at R+3 with 1-cycle memory.
- Simultaneous grant+response+redirect: counters net correctly; both in-flight requests dropped.
- Reset mid-operation: all state cleared asynchronously; in-flight memory responses after reset are ignored by the memory contract (memory shares reset).

## Test plan
- Reset release, memory always granting, 1-cycle latency: pc_d sequence 0x1000,0x1004,0x1008 on consecutive cycles from cycle 2, `valid_d` continuous.
- `stall_d` held 3 cycles with `pc_d=0x1004`: IF/ID holds 0x1004; `imem_req` drops once outstanding+buffered=2; after release 0x1008,0x100C follow back-to-back with no loss or duplication.
- Redirect to 0x2000 with 2 responses in flight: both discarded, `valid_d=0` next cycle, next delivered `pc_d=0x2000`.
- Redirect and `stall_d` asserted same cycle: redirect wins, `valid_d=0`, fetch resumes at target.
- `imem_err=1` on response for 0x1008: delivered with `err_d=1`, `fetch_halt=1` next edge, `imem_req` stays 0; reset clears.
- Redirect to 0x2002: entry delivered with `pc_d=0x2002`, `err_d=1`; redirect to 0xFFFFFFFC: next pc_d 0x00000000.
